// File: rtl/or1200_vlx_unpack.sv
// Variable-length bit extractor for the JPEG decode path (inverse of the VLX packer).
// Latency: inserted bits appear on peek_o one cycle after ack_i; consume takes effect next cycle.
// Backpressure: one registered byte request at a time, held until ack_i; fetch pauses above FILL_LEVEL or on a marker.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   en_i                         fetch enable (an outstanding request is never withdrawn)
//   req_o / ack_i / byte_i       byte fetch handshake
//   peek_o, bits_avail_o         MSB-aligned 16-bit window and valid bit count (0..32)
//   consume_i, consume_n_i       drop 1..16 bits from the head of the window
//   marker_o, marker_code_o      0xFF followed by a non-zero byte was seen; fetching halted
//   err_o                        sticky: illegal consume or unexpected 0xFF sequence
//   spr_addr, write_dp_spr_i,
//   spr_dat_i, spr_dat_o         SPR window: 1 = bit_reg, 0 = status/count
//
// Build option: define VLX_UNPACK_MARKER_DET_EN to halt on JPEG markers; when undefined a
// marker is treated as a stuffing error (0xFF inserted, second byte dropped, err_o set) and
// marker_o / marker_code_o stay 0.
module or1200_vlx_unpack #(
  parameter int FILL_LEVEL = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic        req_o,
  input  logic        ack_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] peek_o,
  output logic [5:0]  bits_avail_o,
  input  logic        consume_i,
  input  logic [4:0]  consume_n_i,
  output logic        marker_o,
  output logic [7:0]  marker_code_o,
  output logic        err_o,
  input  logic        spr_addr,
  input  logic        write_dp_spr_i,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STUFF  = 2'd2,
    ST_MARKER = 2'd3
  } state_t;

  localparam logic [5:0] FILL_CNT = 6'(FILL_LEVEL);
  localparam logic [5:0] MAX_CNT  = 6'd32;

  state_t      state_q, state_d;
  logic [31:0] bit_reg_q, bit_reg_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        req_q, req_d;
  logic        marker_q, marker_d;
  logic [7:0]  marker_code_q, marker_code_d;
  logic        err_q, err_d;

  // SPR writes that arrive while a byte transfer is in flight are parked here and
  // applied once the FSM is back in a quiescent state.
  logic        pend0_q, pend0_d;
  logic [5:0]  pend0_cnt_q, pend0_cnt_d;
  logic        pend1_q, pend1_d;
  logic [31:0] pend1_dat_q, pend1_dat_d;

  // SPR write decode
  logic        idle_like;
  logic        wr_direct;
  logic        wr_defer;
  logic        wr0_apply;
  logic        wr1_apply;
  logic [5:0]  wr0_cnt;
  logic [5:0]  wr0_cnt_sat;
  logic [31:0] wr1_dat;

  always_comb begin
    idle_like   = (state_q == ST_IDLE) || (state_q == ST_MARKER);
    wr_direct   = write_dp_spr_i && idle_like;
    wr_defer    = write_dp_spr_i && !idle_like;
    wr0_apply   = (wr_direct && !spr_addr) || (idle_like && pend0_q);
    wr1_apply   = (wr_direct && spr_addr) || (idle_like && pend1_q);
    wr0_cnt     = (wr_direct && !spr_addr) ? spr_dat_i[5:0] : pend0_cnt_q;
    wr1_dat     = (wr_direct && spr_addr) ? spr_dat_i : pend1_dat_q;
    wr0_cnt_sat = (wr0_cnt > MAX_CNT) ? MAX_CNT : wr0_cnt;
  end

  // State register and all datapath flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      bit_reg_q     <= 32'd0;
      bit_cnt_q     <= 6'd0;
      req_q         <= 1'b0;
      marker_q      <= 1'b0;
      marker_code_q <= 8'd0;
      err_q         <= 1'b0;
      pend0_q       <= 1'b0;
      pend0_cnt_q   <= 6'd0;
      pend1_q       <= 1'b0;
      pend1_dat_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      bit_reg_q     <= bit_reg_d;
      bit_cnt_q     <= bit_cnt_d;
      req_q         <= req_d;
      marker_q      <= marker_d;
      marker_code_q <= marker_code_d;
      err_q         <= err_d;
      pend0_q       <= pend0_d;
      pend0_cnt_q   <= pend0_cnt_d;
      pend1_q       <= pend1_d;
      pend1_dat_q   <= pend1_dat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A status write in this cycle may raise bit_cnt, so hold off fetching until it lands.
        if (!wr0_apply && en_i && (bit_cnt_q <= FILL_CNT) && !marker_q) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (ack_i) begin
          state_d = (byte_i == 8'hFF) ? ST_STUFF : ST_IDLE;
        end
      end
      ST_STUFF: begin
        if (ack_i) begin
          if (byte_i == 8'h00) begin
            state_d = ST_IDLE;
          end else begin
`ifdef VLX_UNPACK_MARKER_DET_EN
            state_d = ST_MARKER;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_MARKER: begin
        if (wr0_apply) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  logic        cons_req;
  logic        cons_ok;
  logic [31:0] reg_c;
  logic [5:0]  cnt_c;
  logic [31:0] keep_c;
  logic        ins_en;
  logic [7:0]  ins_byte;
  logic [5:0]  cnt_sum;

  always_comb begin
    marker_d      = marker_q;
    marker_code_d = marker_code_q;
    err_d         = err_q;
    pend0_d       = pend0_q;
    pend0_cnt_d   = pend0_cnt_q;
    pend1_d       = pend1_q;
    pend1_dat_d   = pend1_dat_q;

    // Any SPR activity in this cycle (direct or a parked write landing) wins over consume.
    cons_req = consume_i && (consume_n_i != 5'd0) && !write_dp_spr_i && !wr0_apply && !wr1_apply;
    cons_ok  = (consume_n_i <= 5'd16) && ({1'b0, consume_n_i} <= bit_cnt_q);

    reg_c = bit_reg_q;
    cnt_c = bit_cnt_q;
    if (cons_req) begin
      if (cons_ok) begin
        reg_c = bit_reg_q << consume_n_i;
        cnt_c = bit_cnt_q - {1'b0, consume_n_i};
      end else begin
        err_d = 1'b1;
      end
    end

    ins_en   = 1'b0;
    ins_byte = byte_i;
    if (ack_i) begin
      case (state_q)
        ST_FETCH: begin
          // A lone 0xFF is held back until the next byte says whether it is stuffing.
          ins_en = (byte_i != 8'hFF);
        end
        ST_STUFF: begin
          ins_byte = 8'hFF;
          if (byte_i == 8'h00) begin
            ins_en = 1'b1;
          end else begin
`ifdef VLX_UNPACK_MARKER_DET_EN
            marker_d      = 1'b1;
            marker_code_d = byte_i;
`else
            ins_en = 1'b1;
            err_d  = 1'b1;
`endif
          end
        end
        default: ins_en = 1'b0;
      endcase
    end

    bit_reg_d = reg_c;
    bit_cnt_d = cnt_c;
    // Bits below the valid count may hold leftovers from an SPR write; clear them
    // before OR-ing the new byte in behind the last valid bit.
    keep_c  = ~(32'hFFFF_FFFF >> cnt_c);
    cnt_sum = cnt_c + 6'd8;
    if (ins_en) begin
      bit_reg_d = (reg_c & keep_c) | ({ins_byte, 24'd0} >> cnt_c);
      bit_cnt_d = (cnt_sum > MAX_CNT) ? MAX_CNT : cnt_sum;
    end

    if (wr1_apply) begin
      bit_reg_d = wr1_dat;
    end
    if (wr0_apply) begin
      bit_cnt_d = wr0_cnt_sat;
      marker_d  = 1'b0;
      err_d     = 1'b0;
    end

    if (idle_like) begin
      pend0_d = 1'b0;
      pend1_d = 1'b0;
    end
    if (wr_defer && !spr_addr) begin
      pend0_d     = 1'b1;
      pend0_cnt_d = spr_dat_i[5:0];
    end
    if (wr_defer && spr_addr) begin
      pend1_d     = 1'b1;
      pend1_dat_d = spr_dat_i;
    end

    req_d = (state_d == ST_FETCH) || (state_d == ST_STUFF);
  end

  logic [15:0] peek_keep;

  always_comb begin
    peek_keep     = ~(16'hFFFF >> bit_cnt_q);
    peek_o        = bit_reg_q[31:16] & peek_keep;
    bits_avail_o  = bit_cnt_q;
    req_o         = req_q;
    marker_o      = marker_q;
    marker_code_o = marker_code_q;
    err_o         = err_q;
    spr_dat_o     = spr_addr ? bit_reg_q
                             : {16'd0, marker_code_q, err_q, marker_q, bit_cnt_q};
  end

endmodule
